// File: rtl/xxd_line_sched_if.sv
// Byte-wide ready/valid stream used on both sides of the xxd line scheduler.
// The master drives valid/data/last; the slave answers with ready.
interface xxd_line_sched_if;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/xxd_line_sched.sv
// Line scheduler for the xxd datapath: fills an external shift buffer with one line,
// then emits {offset, valid_len} followed by the buffered (possibly padded) bytes.
module xxd_line_sched #(
    parameter int unsigned LINE_LEN = 16,
    parameter logic [7:0]  PAD_BYTE = 8'h00
) (
    input  logic                    clk,
    input  logic                    rst,
    xxd_line_sched_if.slave         src,
    xxd_line_sched_if.master        snk,
    output logic                    sr_shift,
    output logic [7:0]              sr_in,
    input  logic [7:0]              sr_out,
    output logic [15:0]             lines_done
);

    localparam logic [7:0] LenB = 8'(LINE_LEN);

    typedef enum logic [2:0] {
        StFill,
        StPad,
        StHdrOfs,
        StHdrLen,
        StDump
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  valid_len_q, valid_len_d;
    logic [7:0]  offset_q, offset_d;
    logic [15:0] lines_done_q, lines_done_d;
    logic [7:0]  cnt_inc;

    assign cnt_inc    = cnt_q + 8'd1;
    assign lines_done = lines_done_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        valid_len_d  = valid_len_q;
        offset_d     = offset_q;
        lines_done_d = lines_done_q;
        src.ready    = 1'b0;
        snk.valid    = 1'b0;
        snk.data     = 8'h00;
        snk.last     = 1'b0;
        sr_shift     = 1'b0;
        sr_in        = PAD_BYTE;

        unique case (state_q)
            StFill: begin
                src.ready = 1'b1;
                if (src.valid) begin
                    sr_shift = 1'b1;
                    sr_in    = src.data;
                    cnt_d    = cnt_inc;
                    // A full line wins over in_last: no padding is needed.
                    if (cnt_inc == LenB) begin
                        valid_len_d = LenB;
                        state_d     = StHdrOfs;
                    end else if (src.last) begin
                        valid_len_d = cnt_inc;
                        state_d     = StPad;
                    end
                end
            end
            StPad: begin
                sr_shift = 1'b1;
                cnt_d    = cnt_inc;
                if (cnt_inc == LenB) begin
                    state_d = StHdrOfs;
                end
            end
            StHdrOfs: begin
                snk.valid = 1'b1;
                snk.data  = offset_q;
                if (snk.ready) begin
                    state_d = StHdrLen;
                end
            end
            StHdrLen: begin
                snk.valid = 1'b1;
                snk.data  = valid_len_q;
                if (snk.ready) begin
                    state_d = StDump;
                    cnt_d   = 8'd0;
                end
            end
            StDump: begin
                snk.valid = 1'b1;
                snk.data  = sr_out;
                if (snk.ready) begin
                    sr_shift = 1'b1;
                    cnt_d    = cnt_inc;
                    if (cnt_inc == LenB) begin
                        cnt_d        = 8'd0;
                        offset_d     = offset_q + valid_len_q;
                        lines_done_d = lines_done_q + 16'd1;
                        state_d      = StFill;
                    end
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase

        // Outputs are forced to their idle values while reset is held.
        if (rst) begin
            src.ready = 1'b1;
            snk.valid = 1'b0;
            snk.data  = 8'h00;
            sr_shift  = 1'b0;
            sr_in     = PAD_BYTE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StFill;
            cnt_q        <= 8'd0;
            valid_len_q  <= 8'd0;
            offset_q     <= 8'd0;
            lines_done_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            valid_len_q  <= valid_len_d;
            offset_q     <= offset_d;
            lines_done_q <= lines_done_d;
        end
    end

endmodule

// File: tb/tb_xxd_line_sched.sv
// Bench for xxd_line_sched: line-level reference model, shift buffer model and scoreboard,
// driven by a scenario table plus hand-written reset and wrap sequences.
module tb_xxd_line_sched;

    localparam int LINE_LEN = 16;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } item_t;

    typedef struct {
        int         n;
        logic [7:0] start;
        bit         use_last;
        bit         rnd;
        int         vp;
        int         rp;
        int         exp_pad;
        int         exp_low;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        sr_shift;
    logic [7:0]  sr_in;
    logic [7:0]  sr_out;
    logic [15:0] lines_done;
    logic [7:0]  sr_mem [LINE_LEN];

    xxd_line_sched_if src_if ();
    xxd_line_sched_if snk_if ();

    xxd_line_sched #(
        .LINE_LEN (LINE_LEN),
        .PAD_BYTE (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src        (src_if),
        .snk        (snk_if),
        .sr_shift   (sr_shift),
        .sr_in      (sr_in),
        .sr_out     (sr_out),
        .lines_done (lines_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External shift buffer: position 0 is the tail, LINE_LEN-1 the head.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINE_LEN; i++) sr_mem[i] <= 8'h00;
        end else if (sr_shift) begin
            sr_mem[0] <= sr_in;
            for (int i = 1; i < LINE_LEN; i++) sr_mem[i] <= sr_mem[i-1];
        end
    end
    assign sr_out = sr_mem[LINE_LEN-1];

    item_t      src_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] chunk_q[$];
    logic [7:0] m_offset;
    int         m_lines;
    int         vprob, rprob;
    int         pad_cnt, low_cnt, acc_cnt;
    bit         stall_prev;
    logic [7:0] stall_data;
    int         n_checks, n_pass;
    vec_t       vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: one line = header {offset, len}, len real bytes, then pad to LINE_LEN.
    task automatic emit_line();
        exp_q.push_back(m_offset);
        exp_q.push_back(8'(chunk_q.size()));
        foreach (chunk_q[k]) exp_q.push_back(chunk_q[k]);
        for (int k = chunk_q.size(); k < LINE_LEN; k++) exp_q.push_back(8'h00);
        m_offset = m_offset + 8'(chunk_q.size());
        m_lines++;
        chunk_q.delete();
    endtask

    task automatic gen_stream(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            item_t it;
            it.data = v.rnd ? 8'($urandom) : 8'(32'(v.start) + i);
            it.last = v.use_last && (i == v.n - 1);
            src_q.push_back(it);
            chunk_q.push_back(it.data);
            if (chunk_q.size() == LINE_LEN || it.last) emit_line();
        end
    endtask

    task automatic drive_inputs();
        bit v;
        v = (src_q.size() > 0) && ($urandom_range(99) < 32'(vprob));
        src_if.valid = v;
        src_if.data  = v ? src_q[0].data : 8'($urandom);
        src_if.last  = v ? src_q[0].last : 1'($urandom_range(1));
        snk_if.ready = $urandom_range(99) < 32'(rprob);
    endtask

    // Observe the settled cycle, then advance one clock and drive new inputs.
    task automatic step();
        #2;
        if (!rst) begin
            if (stall_prev) begin
                chk("stall_valid", 32'(snk_if.valid), 32'd1);
                chk("stall_data", 32'(snk_if.data), 32'(stall_data));
            end
            if (snk_if.valid && !snk_if.ready) chk("stall_no_shift", 32'(sr_shift), 32'd0);
            if (!src_if.ready) low_cnt++;
            if (sr_shift && !(src_if.valid && src_if.ready) && !(snk_if.valid && snk_if.ready))
                pad_cnt++;
            if (src_if.valid && src_if.ready && src_q.size() > 0) void'(src_q.pop_front());
            if (snk_if.valid && snk_if.ready) begin
                acc_cnt++;
                if (exp_q.size() == 0) chk("out_extra", 32'(exp_q.size()), 32'd1);
                else chk("out_data", 32'(snk_if.data), 32'(exp_q.pop_front()));
            end
            stall_prev = snk_if.valid && !snk_if.ready;
            stall_data = snk_if.data;
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int budget;
        vprob   = v.vp;
        rprob   = v.rp;
        pad_cnt = 0;
        low_cnt = 0;
        gen_stream(v);
        drive_inputs();
        budget = 5000;
        while ((src_q.size() > 0 || exp_q.size() > 0) && budget > 0) begin
            step();
            budget--;
        end
        chk({name, "_timeout"}, 32'(budget > 0), 32'd1);
        src_q.delete();
        exp_q.delete();
        chk({name, "_pad_cycles"}, 32'(pad_cnt), 32'(v.exp_pad));
        if (v.exp_low >= 0) chk({name, "_ready_low"}, 32'(low_cnt), 32'(v.exp_low));
        #2;
        chk({name, "_lines_done"}, 32'(lines_done), 32'(m_lines & 16'hffff));
        chk({name, "_idle_ready"}, 32'(src_if.ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int budget;
        n_checks = 0; n_pass = 0; m_offset = 8'h00; m_lines = 0;
        acc_cnt = 0; stall_prev = 1'b0; stall_data = 8'h00;
        vprob = 100; rprob = 100;

        vecs[0] = '{16, 8'h00, 1'b0, 1'b0, 100, 100, 0, 18};
        vecs[1] = '{32, 8'h00, 1'b0, 1'b0, 100, 100, 0, 36};
        vecs[2] = '{5, 8'h20, 1'b1, 1'b0, 100, 100, 11, 29};
        vecs[3] = '{16, 8'h00, 1'b0, 1'b0, 100, 50, 0, -1};
        vecs[4] = '{16, 8'h60, 1'b1, 1'b0, 100, 100, 0, 18};
        vecs[5] = '{23, 8'h00, 1'b1, 1'b1, 70, 60, 9, -1};
        vecs[6] = '{3, 8'h00, 1'b1, 1'b1, 50, 100, 13, 31};
        vecs[7] = '{15, 8'h00, 1'b1, 1'b1, 80, 100, 1, 19};

        rst = 1'b1;
        src_if.valid = 1'b1; src_if.data = 8'h5a; src_if.last = 1'b0;
        snk_if.ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_in_ready", 32'(src_if.ready), 32'd1);
        chk("rst_out_valid", 32'(snk_if.valid), 32'd0);
        chk("rst_sr_shift", 32'(sr_shift), 32'd0);
        chk("rst_out_data", 32'(snk_if.data), 32'd0);
        chk("rst_lines_done", 32'(lines_done), 32'd0);
        rst = 1'b0;
        src_if.valid = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(src_if.ready), 32'd1);
        chk("post_rst_out_valid", 32'(snk_if.valid), 32'd0);

        for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Reset while draining: 2 header bytes plus 5 data bytes already accepted.
        vprob = 100; rprob = 100;
        gen_stream('{16, 8'h50, 1'b0, 1'b0, 100, 100, 0, 0});
        drive_inputs();
        acc_cnt = 0;
        budget = 500;
        while (acc_cnt < 7 && budget > 0) begin
            step();
            budget--;
        end
        chk("mid_dump_timeout", 32'(budget > 0), 32'd1);
        rst = 1'b1;
        #2;
        chk("mid_rst_out_valid", 32'(snk_if.valid), 32'd0);
        chk("mid_rst_sr_shift", 32'(sr_shift), 32'd0);
        chk("mid_rst_in_ready", 32'(src_if.ready), 32'd1);
        step();
        rst = 1'b0;
        src_q.delete(); exp_q.delete(); chunk_q.delete();
        m_offset = 8'h00; m_lines = 0;
        #1;
        chk("after_rst_in_ready", 32'(src_if.ready), 32'd1);
        chk("after_rst_lines_done", 32'(lines_done), 32'd0);
        chk("after_rst_out_valid", 32'(snk_if.valid), 32'd0);
        run_vec("after_rst", '{16, 8'h40, 1'b0, 1'b0, 100, 100, 0, 18});

        // Seventeen more full lines from a fresh reset: the 17th header offset wraps to 0x00.
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_offset = 8'h00; m_lines = 0;
        run_vec("wrap17", '{272, 8'h00, 1'b0, 1'b1, 100, 100, 0, 306});
        chk("wrap17_lines", 32'(lines_done), 32'd17);
        chk("wrap17_model_offset", 32'(m_offset), 32'd16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
